rr_mutex_arbiter: RTL and testbench

- Shares one iterative, single-thread datapath (e.g. a Montgomery multiply core) between N_REQ requesters.
- Only one operation is in flight at a time. Ownership is granted round-robin and held until the owner accepts the result.
- Sits between requester valid/ready ports and the datapath's command and response ports. Routes each response back to the owner.

---
 rtl/rr_mutex_arbiter.sv | 142 ++++++++++++++
 tb/tb_rr_mutex_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mutex_arbiter.sv
// Round-robin mutex arbiter: lends one single-thread datapath to N_REQ
// requesters, one operation at a time, and routes each result to its owner.
module rr_mutex_arbiter #(
  parameter  int unsigned N_REQ = 2,
  parameter  int unsigned DW    = 32,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic                dp_valid,
  input  logic                dp_ready,
  output logic [DW-1:0]       dp_data,
  input  logic                dp_rsp_valid,
  output logic                dp_rsp_ready,
  input  logic [DW-1:0]       dp_rsp_data,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [DW-1:0]       rsp_data,
  output logic                busy,
  output logic [IW-1:0]       owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;

  logic            w_any;
  logic            w_hi_found;
  logic            w_lo_found;
  logic [IW-1:0]   w_hi_idx;
  logic [IW-1:0]   w_lo_idx;
  logic [IW-1:0]   w_winner;
  logic            w_own_valid;
  logic            w_own_rsp_ready;
  logic [DW-1:0]   w_own_data;
  logic            w_cmd_fire;
  logic            w_rsp_fire;

  // Round-robin pick: first valid at or above ptr, else first valid from 0.
  always_comb begin
    w_any      = |req_valid;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && (IW'(i) >= r_ptr) && !w_hi_found) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IW'(i);
      end
      if (req_valid[i] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IW'(i);
      end
    end
    w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // Select the current owner's command and response-ready lanes.
  always_comb begin
    w_own_valid     = 1'b0;
    w_own_rsp_ready = 1'b0;
    w_own_data      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IW'(i) == r_owner) begin
        w_own_valid     = req_valid[i];
        w_own_rsp_ready = rsp_ready[i];
        w_own_data      = req_data[i*DW +: DW];
      end
    end
    w_cmd_fire = (r_state == S_ISSUE) && w_own_valid && dp_ready;
    w_rsp_fire = (r_state == S_WAIT) && dp_rsp_valid && w_own_rsp_ready;
  end

  // Lock FSM: grant in IDLE, hold through command issue and result return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_winner;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_cmd_fire) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_rsp_fire) begin
            r_state <= S_IDLE;
            r_ptr   <= (r_owner == IW'(N_REQ-1)) ? '0 : r_owner + IW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake steering; everything collapses to zero whenever state is IDLE.
  always_comb begin
    req_ready    = '0;
    dp_valid     = 1'b0;
    dp_data      = '0;
    dp_rsp_ready = 1'b0;
    rsp_valid    = '0;
    rsp_data     = '0;
    case (r_state)
      S_ISSUE: begin
        dp_valid = w_own_valid;
        dp_data  = w_own_data;
        for (int unsigned i = 0; i < N_REQ; i++) begin
          req_ready[i] = (IW'(i) == r_owner) && dp_ready;
        end
      end
      S_WAIT: begin
        rsp_data     = dp_rsp_data;
        dp_rsp_ready = w_own_rsp_ready;
        for (int unsigned i = 0; i < N_REQ; i++) begin
          rsp_valid[i] = (IW'(i) == r_owner) && dp_rsp_valid;
        end
      end
      default: ;
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign owner = r_owner;

endmodule

// File: tb/tb_rr_mutex_arbiter.sv
// Bench for rr_mutex_arbiter: requester queues, a datapath model that returns
// cmd ^ 8'h99 after a programmable delay, and a grant-order scoreboard.
module tb_rr_mutex_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic            dp_valid;
  logic            dp_ready;
  logic [DW-1:0]   dp_data;
  logic            dp_rsp_valid;
  logic            dp_rsp_ready;
  logic [DW-1:0]   dp_rsp_data;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            busy;
  logic [1:0]      owner;

  rr_mutex_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .dp_valid     (dp_valid),
    .dp_ready     (dp_ready),
    .dp_data      (dp_data),
    .dp_rsp_valid (dp_rsp_valid),
    .dp_rsp_ready (dp_rsp_ready),
    .dp_rsp_data  (dp_rsp_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .owner        (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_cmd_q[$];
  exp_t       exp_rsp_q[$];
  logic [7:0] rq_q [3][$];
  int         hs_cyc[$];

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;
  logic       inflight = 1'b0;
  logic       dp_busy  = 1'b0;
  int         dp_cnt   = 0;
  int         dp_lat   = 0;
  logic [7:0] dp_res   = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < 3; i++) begin
      if (rq_q[i].size() != 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = rq_q[i][0];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  // Queue a command at requester r and record the grant order the bench expects.
  task automatic push(input int r, input logic [7:0] d);
    exp_t e;
    e.idx  = 2'(r);
    e.data = d;
    rq_q[r].push_back(d);
    exp_cmd_q.push_back(e);
  endtask

  task automatic settle();
    #2;
  endtask

  // One clock: monitor at negedge, advance models after posedge.
  task automatic tick();
    logic [2:0] acc;
    logic       cmd_hs;
    logic       rsp_hs;
    exp_t       e;
    exp_t       r;
    @(negedge clk);
    check("onehot0_rsp_valid", 32'($onehot0(rsp_valid)), 32'd1);
    check("onehot0_req_ready", 32'($onehot0(req_ready)), 32'd1);
    if (inflight) begin
      check("dp_valid_in_wait", 32'(dp_valid), 32'd0);
      check("req_ready_in_wait", 32'(req_ready), 32'd0);
    end else begin
      check("rsp_valid_outside_wait", 32'(rsp_valid), 32'd0);
      check("dp_rsp_ready_outside_wait", 32'(dp_rsp_ready), 32'd0);
    end
    acc    = req_ready & req_valid;
    cmd_hs = dp_valid && dp_ready;
    rsp_hs = |(rsp_valid & rsp_ready);
    if (cmd_hs) begin
      check("one_cmd_per_lock", 32'(inflight), 32'd0);
      check("cmd_expected", 32'(exp_cmd_q.size() != 0), 32'd1);
      hs_cyc.push_back(cyc);
      dp_res = dp_data ^ 8'h99;
      if (exp_cmd_q.size() != 0) begin
        e = exp_cmd_q.pop_front();
        check("cmd_owner", 32'(owner), 32'(e.idx));
        check("cmd_data", 32'(dp_data), 32'(e.data));
        check("cmd_req_ready", 32'(acc), 32'(onehot(e.idx)));
        r.idx  = e.idx;
        r.data = e.data ^ 8'h99;
        exp_rsp_q.push_back(r);
      end
    end
    if (rsp_hs) begin
      check("rsp_expected", 32'(exp_rsp_q.size() != 0), 32'd1);
      if (exp_rsp_q.size() != 0) begin
        r = exp_rsp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(onehot(r.idx)));
        check("rsp_data", 32'(rsp_data), 32'(r.data));
        check("dp_rsp_ready", 32'(dp_rsp_ready), 32'd1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_hs) begin
      inflight     = 1'b0;
      dp_busy      = 1'b0;
      dp_rsp_valid = 1'b0;
      dp_rsp_data  = 8'h00;
    end
    if (cmd_hs) begin
      inflight = 1'b1;
      dp_busy  = 1'b1;
      dp_cnt   = dp_lat;
    end
    if (dp_busy && !dp_rsp_valid) begin
      if (dp_cnt == 0) begin
        dp_rsp_valid = 1'b1;
        dp_rsp_data  = dp_res;
      end else begin
        dp_cnt--;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (acc[i] && rq_q[i].size() != 0) void'(rq_q[i].pop_front());
    end
    drive_reqs();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0 || inflight) && n < budget) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_cmd_q.size() + exp_rsp_q.size()), 32'd0);
  endtask

  // Assert reset mid-cycle, check outputs drop immediately, flush bench state.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_dp_valid", 32'(dp_valid), 32'd0);
    check("rst_dp_rsp_ready", 32'(dp_rsp_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_dp_data", 32'(dp_data), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    hs_cyc.delete();
    for (int i = 0; i < 3; i++) rq_q[i].delete();
    inflight     = 1'b0;
    dp_busy      = 1'b0;
    dp_rsp_valid = 1'b0;
    dp_rsp_data  = 8'h00;
    dp_ready     = 1'b1;
    rsp_ready    = 3'b111;
    drive_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    dp_ready     = 1'b1;
    dp_rsp_valid = 1'b0;
    dp_rsp_data  = 8'h00;
    rsp_ready    = 3'b111;
    @(posedge clk);
    #1;
    do_reset();

    // Single request from requester 1, then ptr=2 makes 2 beat 0.
    dp_lat = 2;
    push(1, 8'hA5);
    drive_reqs();
    settle();
    check("t1_idle_dp_valid", 32'(dp_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    tick();
    settle();
    check("t1_lat_dp_valid", 32'(dp_valid), 32'd1);
    check("t1_lat_dp_data", 32'(dp_data), 32'hA5);
    check("t1_lat_req_ready", 32'(req_ready), 32'b010);
    check("t1_owner", 32'(owner), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_idle(30);
    settle();
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_owner_held", 32'(owner), 32'd1);
    push(2, 8'h22);
    push(0, 8'h11);
    drive_reqs();
    wait_idle(40);

    // Contention from reset: order 0,1,2,0,1,2 with spacing latency+2.
    do_reset();
    dp_lat = 1;
    push(0, 8'h01);
    push(1, 8'h02);
    push(2, 8'h03);
    push(0, 8'h04);
    push(1, 8'h05);
    push(2, 8'h06);
    drive_reqs();
    wait_idle(100);
    check("t2_hs_count", 32'(hs_cyc.size()), 32'd6);
    for (int i = 1; i < hs_cyc.size(); i++) begin
      check("t2_issue_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd4);
    end

    // Mutex hold: result 20 cycles after issue, requester 1 waits throughout.
    hs_cyc.delete();
    dp_lat = 19;
    push(0, 8'h30);
    push(1, 8'h31);
    drive_reqs();
    wait_idle(120);
    check("t3_hs_count", 32'(hs_cyc.size()), 32'd2);
    if (hs_cyc.size() == 2) check("t3_mutex_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd22);

    // Back-pressure on command (5 cycles) and on result (4 cycles).
    dp_lat    = 0;
    dp_ready  = 1'b0;
    rsp_ready = 3'b000;
    push(2, 8'hD7);
    drive_reqs();
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t4_issue_dp_valid", 32'(dp_valid), 32'd1);
      check("t4_issue_req_ready", 32'(req_ready), 32'd0);
      check("t4_issue_busy", 32'(busy), 32'd1);
      tick();
    end
    dp_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t4_hold_rsp_valid", 32'(rsp_valid), 32'b100);
      check("t4_hold_rsp_data", 32'(rsp_data), 32'h4E);
      check("t4_hold_dp_rsp_ready", 32'(dp_rsp_ready), 32'd0);
      check("t4_hold_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 3'b111;
    wait_idle(20);

    // Stray response in IDLE, then wrap: 0 beats 2 after owner 2 finished.
    settle();
    dp_rsp_valid = 1'b1;
    dp_rsp_data  = 8'h77;
    #1;
    check("t5_stray_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_stray_dp_rsp_ready", 32'(dp_rsp_ready), 32'd0);
    check("t5_stray_rsp_data", 32'(rsp_data), 32'd0);
    tick();
    dp_rsp_valid = 1'b0;
    dp_rsp_data  = 8'h00;
    push(0, 8'h10);
    push(2, 8'h20);
    drive_reqs();
    wait_idle(40);

    // Reset while requester 2 holds a pending result.
    dp_lat    = 2;
    rsp_ready = 3'b000;
    push(2, 8'h5B);
    drive_reqs();
    n = 0;
    while (rsp_valid !== 3'b100 && n < 20) begin
      tick();
      settle();
      n++;
    end
    check("t6_reached_wait", 32'(rsp_valid), 32'b100);
    do_reset();
    push(2, 8'h6C);
    drive_reqs();
    settle();
    check("t6_idle_dp_valid", 32'(dp_valid), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    tick();
    settle();
    check("t6_issue_dp_valid", 32'(dp_valid), 32'd1);
    check("t6_issue_owner", 32'(owner), 32'd2);
    check("t6_issue_dp_data", 32'(dp_data), 32'h6C);
    wait_idle(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
